// File: rtl/mips_ex_unit.sv
// Execute stage of the five-stage MIPS core: main control, ALU control and a 32-bit ALU, one registered stage.
// Define OVF_DETECT_EN to add the registered signed-overflow output ovf.
module mips_ex_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [3:0]       aluctl,
    output logic [4:0]       wrreg,
    output logic             regdst,
    output logic             branch,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrc,
    output logic [1:0]       aluop,
`ifdef OVF_DETECT_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] store_data
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;
    localparam logic [3:0] CTL_INV = 4'b1111;

    function automatic logic [3:0] alu_ctl(input logic [1:0] op, input logic [5:0] fn);
        logic [3:0] c;
        c = CTL_INV;
        case (op)
            2'b00: c = CTL_ADD;
            2'b01: c = CTL_SUB;
            2'b10: begin
                case (fn)
                    6'b100000: c = CTL_ADD;
                    6'b100010: c = CTL_SUB;
                    6'b100100: c = CTL_AND;
                    6'b100101: c = CTL_OR;
                    6'b100110: c = CTL_XOR;
                    6'b100111: c = CTL_NOR;
                    6'b101010: c = CTL_SLT;
                    default:   c = CTL_INV;
                endcase
            end
            default: c = CTL_INV;
        endcase
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] alu_exec(input logic [3:0] ctl,
                                                  input logic signed [WIDTH-1:0] a,
                                                  input logic signed [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (ctl)
            CTL_AND: r = a & b;
            CTL_OR:  r = a | b;
            CTL_ADD: r = a + b;
            CTL_SUB: r = a - b;
            CTL_XOR: r = a ^ b;
            CTL_NOR: r = ~(a | b);
            CTL_SLT: r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

`ifdef OVF_DETECT_EN
    function automatic logic ovf_calc(input logic [3:0] ctl, input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r);
        logic o;
        o = 1'b0;
        if (ctl == CTL_ADD)
            o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        else if (ctl == CTL_SUB)
            o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        return o;
    endfunction
`endif

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm_ext;
    logic             regdst_d, branch_d, memread_d, memwrite_d, memtoreg_d, regwrite_d, alusrc_d;
    logic [1:0]       aluop_d;
    logic [3:0]       aluctl_d;
    logic signed [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] result_d;
    logic [4:0]       wrreg_d;
    // rs field and shamt are decoded elsewhere in the core and intentionally ignored here.
    logic             unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign imm_ext       = {{(WIDTH-16){instr[15]}}, instr[15:0]};
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    always_comb begin
        regdst_d   = 1'b0;
        alusrc_d   = 1'b0;
        memtoreg_d = 1'b0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        branch_d   = 1'b0;
        aluop_d    = 2'b00;
        case (opcode)
            OP_RTYPE: begin regdst_d = 1'b1; regwrite_d = 1'b1; aluop_d = 2'b10; end
            OP_LW:    begin alusrc_d = 1'b1; memtoreg_d = 1'b1; regwrite_d = 1'b1; memread_d = 1'b1; end
            OP_SW:    begin alusrc_d = 1'b1; memwrite_d = 1'b1; end
            OP_BEQ:   begin branch_d = 1'b1; aluop_d = 2'b01; end
            OP_ADDI:  begin alusrc_d = 1'b1; regwrite_d = 1'b1; end
            default:  ;
        endcase
    end

    assign aluctl_d = alu_ctl(aluop_d, funct);
    assign op_a     = rs_data;
    assign op_b     = alusrc_d ? imm_ext : rt_data;
    assign result_d = alu_exec(aluctl_d, op_a, op_b);
    assign wrreg_d  = regdst_d ? instr[15:11] : instr[20:16];

    // Stage boundary: everything the next pipeline stage needs is captured here.
    logic [WIDTH-1:0] alu_result_q, store_data_q;
    logic             zero_q, regdst_q, branch_q, memread_q, memwrite_q, memtoreg_q, regwrite_q, alusrc_q;
    logic [3:0]       aluctl_q;
    logic [4:0]       wrreg_q;
    logic [1:0]       aluop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            zero_q       <= 1'b0;
            aluctl_q     <= '0;
            wrreg_q      <= '0;
            regdst_q     <= 1'b0;
            branch_q     <= 1'b0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            alusrc_q     <= 1'b0;
            aluop_q      <= '0;
        end else begin
            alu_result_q <= result_d;
            store_data_q <= rt_data;
            zero_q       <= (result_d == '0);
            aluctl_q     <= aluctl_d;
            wrreg_q      <= wrreg_d;
            regdst_q     <= regdst_d;
            branch_q     <= branch_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            alusrc_q     <= alusrc_d;
            aluop_q      <= aluop_d;
        end
    end

`ifdef OVF_DETECT_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_calc(aluctl_d, op_a, op_b, result_d);
    end
    assign ovf = ovf_q;
`endif

    assign alu_result = alu_result_q;
    assign store_data = store_data_q;
    assign zero       = zero_q;
    assign aluctl     = aluctl_q;
    assign wrreg      = wrreg_q;
    assign regdst     = regdst_q;
    assign branch     = branch_q;
    assign memread    = memread_q;
    assign memwrite   = memwrite_q;
    assign memtoreg   = memtoreg_q;
    assign regwrite   = regwrite_q;
    assign alusrc     = alusrc_q;
    assign aluop      = aluop_q;

endmodule

// File: tb/tb_mips_ex_unit.sv
// Self-checking bench for mips_ex_unit: scoreboard of model results, compared one edge after each instruction.
module tb_mips_ex_unit;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [3:0]  ctl;
        logic [4:0]  wrreg;
        logic        regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
        logic [1:0]  aluop;
        logic [31:0] sd;
        logic        ovf;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr, rs_data, rt_data;
    logic [31:0] alu_result, store_data;
    logic        zero, regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
    logic [3:0]  aluctl;
    logic [4:0]  wrreg;
    logic [1:0]  aluop;
`ifdef OVF_DETECT_EN
    logic        ovf;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t sb[$];

    mips_ex_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_result(alu_result), .zero(zero), .aluctl(aluctl), .wrreg(wrreg),
        .regdst(regdst), .branch(branch), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrc(alusrc), .aluop(aluop),
`ifdef OVF_DETECT_EN
        .ovf(ovf),
`endif
        .store_data(store_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic out_t sample();
        out_t s;
        s.res = alu_result; s.zero = zero; s.ctl = aluctl; s.wrreg = wrreg;
        s.regdst = regdst; s.branch = branch; s.memread = memread; s.memwrite = memwrite;
        s.memtoreg = memtoreg; s.regwrite = regwrite; s.alusrc = alusrc; s.aluop = aluop;
        s.sd = store_data;
`ifdef OVF_DETECT_EN
        s.ovf = ovf;
`else
        s.ovf = 1'b0;
`endif
        return s;
    endfunction

    // Instruction-level reference: what each instruction should produce.
    function automatic out_t ref_model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        out_t        o;
        logic [31:0] sext, bo;
        logic [32:0] w;
        o = '0;
        sext = {{16{i[15]}}, i[15:0]};
        bo = b;
        o.sd = b;
        o.wrreg = i[20:16];
        case (i[31:26])
            6'h00: begin
                o.regdst = 1'b1; o.regwrite = 1'b1; o.aluop = 2'b10; o.wrreg = i[15:11];
                case (i[5:0])
                    6'h20: begin o.ctl = 4'h2; o.res = a + b; end
                    6'h22: begin o.ctl = 4'h6; o.res = a - b; end
                    6'h24: begin o.ctl = 4'h0; o.res = a & b; end
                    6'h25: begin o.ctl = 4'h1; o.res = a | b; end
                    6'h26: begin o.ctl = 4'hD; o.res = a ^ b; end
                    6'h27: begin o.ctl = 4'hC; o.res = ~(a | b); end
                    6'h2A: begin o.ctl = 4'h7; o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    default: begin o.ctl = 4'hF; o.res = 32'd0; end
                endcase
            end
            6'h23: begin
                o.alusrc = 1'b1; o.memtoreg = 1'b1; o.regwrite = 1'b1; o.memread = 1'b1;
                o.ctl = 4'h2; bo = sext; o.res = a + sext;
            end
            6'h2B: begin o.alusrc = 1'b1; o.memwrite = 1'b1; o.ctl = 4'h2; bo = sext; o.res = a + sext; end
            6'h04: begin o.branch = 1'b1; o.aluop = 2'b01; o.ctl = 4'h6; o.res = a - b; end
            6'h08: begin o.alusrc = 1'b1; o.regwrite = 1'b1; o.ctl = 4'h2; bo = sext; o.res = a + sext; end
            default: begin o.ctl = 4'h2; o.res = a + b; end
        endcase
        o.zero = (o.res == 32'd0);
`ifdef OVF_DETECT_EN
        if (o.ctl == 4'h2) begin
            w = {a[31], a} + {bo[31], bo};
            o.ovf = w[32] ^ w[31];
        end else if (o.ctl == 4'h6) begin
            w = {a[31], a} - {bo[31], bo};
            o.ovf = w[32] ^ w[31];
        end
`else
        w = '0;
        o.ovf = w[0];
`endif
        return o;
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        instr = i; rs_data = a; rt_data = b;
        sb.push_back(ref_model(i, a, b));
    endtask

    task automatic test_reset();
        out_t got;
        got = sample();
        n_checks++;
        if (got !== out_t'(0)) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0", got);
        end
    endtask

    task automatic test_rtype();
        logic [31:0] ti[8], ta[8], tb[8];
        out_t got, exp;
        ti = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825,
               32'h00221826, 32'h00221827, 32'h00221800, 32'h00221820};
        ta = '{32'd5, 32'd9, 32'hF0F0_1234, 32'hF0F0_0000, 32'hAAAA_5555, 32'h0F0F_0000, 32'd3, 32'hFFFF_FFFF};
        tb = '{32'd7, 32'd9, 32'hFF00_FF00, 32'h0000_0F0F, 32'hFFFF_0000, 32'h0000_F0F0, 32'd4, 32'd1};
        for (int k = 0; k < 8; k++) begin
            drive(ti[k], ta[k], tb[k]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rtype[%0d] got=%h exp=%h", k, got, exp);
            end
            if (k == 0) begin
                n_checks++;
                if (alu_result !== 32'd12 || zero !== 1'b0 || aluctl !== 4'b0010 ||
                    regdst !== 1'b1 || regwrite !== 1'b1 || wrreg !== 5'd3) begin
                    n_fail++;
                    $display("FAIL r_add res=%h zero=%b ctl=%b wrreg=%0d exp res=0000000c zero=0 ctl=0010 wrreg=3",
                             alu_result, zero, aluctl, wrreg);
                end
            end else if (k == 1) begin
                n_checks++;
                if (alu_result !== 32'd0 || zero !== 1'b1 || aluctl !== 4'b0110) begin
                    n_fail++;
                    $display("FAIL r_sub_equal res=%h zero=%b ctl=%b exp res=0 zero=1 ctl=0110", alu_result, zero, aluctl);
                end
            end else if (k == 6) begin
                n_checks++;
                if (alu_result !== 32'd0 || zero !== 1'b1 || aluctl !== 4'b1111) begin
                    n_fail++;
                    $display("FAIL bad_funct res=%h zero=%b ctl=%b exp res=0 zero=1 ctl=1111", alu_result, zero, aluctl);
                end
            end
        end
    endtask

    task automatic test_slt();
        out_t got, exp;
        logic [31:0] want;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(32'h0022182A, 32'hFFFF_FFFF, 32'd1);
            else        drive(32'h0022182A, 32'd1, 32'hFFFF_FFFF);
            want = (k == 0) ? 32'd1 : 32'd0;
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_checks++;
            if (got !== exp || alu_result !== want || aluctl !== 4'b0111) begin
                n_fail++;
                $display("FAIL slt[%0d] got=%h exp=%h res=%h want=%h", k, got, exp, alu_result, want);
            end
        end
    endtask

    task automatic test_mem();
        logic [31:0] ti[3], ta[3], tb[3], want[3];
        out_t got, exp;
        ti = '{32'h8C220008, 32'h8C22FFF8, 32'hAC220004};
        ta = '{32'h100, 32'h100, 32'h200};
        tb = '{32'h0, 32'h55, 32'hDEAD};
        want = '{32'h108, 32'hF8, 32'h204};
        for (int k = 0; k < 3; k++) begin
            drive(ti[k], ta[k], tb[k]);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_checks++;
            if (got !== exp || alu_result !== want[k]) begin
                n_fail++;
                $display("FAIL mem[%0d] got=%h exp=%h res=%h want=%h", k, got, exp, alu_result, want[k]);
            end
        end
    endtask

    task automatic test_branch_invalid();
        out_t got, exp;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: drive(32'h10220003, 32'd4, 32'd4);
                1: drive(32'h10220003, 32'd4, 32'd5);
                default: drive(32'hFC221820, 32'd6, 32'd7);
            endcase
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL branch_inv[%0d] got=%h exp=%h", k, got, exp);
            end
            if (k == 0) begin
                n_checks++;
                if (branch !== 1'b1 || zero !== 1'b1 || regwrite !== 1'b0 || aluop !== 2'b01) begin
                    n_fail++;
                    $display("FAIL beq_taken branch=%b zero=%b regwrite=%b aluop=%b exp 1 1 0 01",
                             branch, zero, regwrite, aluop);
                end
            end else if (k == 2) begin
                n_checks++;
                if ({regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL invalid_opcode ctrl=%b exp=000000000",
                             {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        out_t got, exp;
        drive(32'h00221820, 32'd5, 32'd7);
        @(posedge clk); #1;
        exp = sb.pop_front();
        got = sample();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL pre_reset got=%h exp=%h", got, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        got = sample();
        n_checks++;
        if (got !== out_t'(0)) begin
            n_fail++;
            $display("FAIL async_clear got=%h exp=0", got);
        end
        @(posedge clk); #1;
        got = sample();
        n_checks++;
        if (got !== out_t'(0)) begin
            n_fail++;
            $display("FAIL reset_hold got=%h exp=0", got);
        end
        drive(32'h8C220008, 32'h100, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp = sb.pop_front();
        got = sample();
        n_checks++;
        if (got !== exp || alu_result !== 32'h108) begin
            n_fail++;
            $display("FAIL reset_release got=%h exp=%h", got, exp);
        end
    endtask

`ifdef OVF_DETECT_EN
    task automatic test_overflow();
        out_t got, exp;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: drive(32'h00221820, 32'h7FFF_FFFF, 32'd1);
                1: drive(32'h00221822, 32'h8000_0000, 32'd1);
                default: drive(32'h00221820, 32'h7FFF_FFFE, 32'd1);
            endcase
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL ovf[%0d] got=%h exp=%h", k, got, exp);
            end
            if (k == 0) begin
                n_checks++;
                if (ovf !== 1'b1 || alu_result !== 32'h8000_0000) begin
                    n_fail++;
                    $display("FAIL ovf_add ovf=%b res=%h exp ovf=1 res=80000000", ovf, alu_result);
                end
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        out_t got, exp;
        logic [5:0]  ops[6], fns[9];
        logic [31:0] i, a, b;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h03, 6'h21};
        for (int k = 0; k < 60; k++) begin
            i = $urandom;
            i[31:26] = ops[$urandom_range(0, 5)];
            if (i[31:26] == 6'h00) i[5:0] = fns[$urandom_range(0, 8)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            drive(i, a, b);
            @(posedge clk); #1;
            exp = sb.pop_front();
            got = sample();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL b2b[%0d] instr=%h a=%h b=%h got=%h exp=%h", k, i, a, b, got, exp);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_rtype();
        test_slt();
        test_mem();
        test_branch_invalid();
        test_async_reset();
`ifdef OVF_DETECT_EN
        test_overflow();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_ex_unit.md
Name: mips_ex_unit

Overview:
- Combined main-control decoder, ALU-control decoder and 32-bit ALU for the five-stage MIPS core.
- Takes a fetched instruction plus the two register operands, and decodes opcode and funct.
- Selects the ALU B operand, executes, and registers the result, flags and control bundle for the next pipeline stage.
- Latency: one clock.

Parameters:
- WIDTH, 32, datapath width of operands and result; must be 32 for MIPS encoding.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0]
- rs_data  in  32  value of $rs
- rt_data  in  32  value of $rt
- alu_result  out  32  registered ALU output
- zero  out  1  registered; 1 when the ALU output is 0
- aluctl  out  4  registered ALU control code
- wrreg  out  5  registered destination register: rd if regdst, else rt
- regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc  out  1 each  registered control signals
- aluop  out  2  registered ALU op class
- store_data  out  32  registered rt_data, used as store data

Behaviour:
- Decode and execute are purely combinational from instr, rs_data and rt_data; every output is captured at posedge clk.
- Result for the instruction presented in cycle N is visible after edge N+1. No handshake; a new instruction is accepted every cycle.
- rst_n low: all outputs 0 immediately, asynchronously. The register holds 0 until the first rising edge after rst_n deasserts.
- Main control by opcode, listing regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, then aluop:
  - 000000 R-type: 1,0,0,1,0,0,0, aluop=10
  - 100011 lw: 0,1,1,1,1,0,0, aluop=00
  - 101011 sw: 0,1,0,0,0,1,0, aluop=00
  - 000100 beq: 0,0,0,0,0,0,1, aluop=01
  - 001000 addi: 0,1,0,1,0,0,0, aluop=00
  - any other opcode: all signals 0, aluop=00 (bubble, no side effects)
- ALU control:
  - aluop 00 -> 0010 (add)
  - aluop 01 -> 0110 (sub)
  - aluop 11 -> 1111
  - aluop 10 decodes funct:
    - 100000 add -> 0010
    - 100010 sub -> 0110
    - 100100 and -> 0000
    - 100101 or -> 0001
    - 100110 xor -> 1101
    - 100111 nor -> 1100
    - 101010 slt -> 0111
    - any other funct -> 1111
- B operand: sign-extended imm when alusrc=1, else rt_data.
- ALU ops:
  - 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 1101 A^B; 1100 ~(A|B)
  - 0111: 1 if signed A<B, else 0
  - 1111 or any unlisted code: 0
  - add/sub wrap modulo 2^32; no trap.
- zero is computed from the final ALU output, including the 0 produced by invalid codes.
- Shifts, jumps and shamt are unused and ignored.

Optional Feature:
- Macro OVF_DETECT_EN.
- Defined: adds a registered output port ovf (1 bit, reset 0). ovf is set when a signed add (0010) or sub (0110) overflows, i.e. operands have the same sign (add) or opposite signs (sub) and the result sign differs from A. For all other ops ovf=0. alu_result still carries the wrapped value.
- Undefined: the ovf port and its logic are absent; nothing else changes.

Test Plan:
- R-add: instr=0x00221820, rs_data=5, rt_data=7 -> next edge alu_result=12, zero=0, aluctl=0010, regdst=1, regwrite=1, wrreg=3.
- R-sub equal: instr=0x00221822, rs_data=rt_data=9 -> alu_result=0, zero=1, aluctl=0110.
- slt signed: instr=0x0022182A, rs_data=0xFFFFFFFF, rt_data=1 -> alu_result=1, aluctl=0111. Operands swapped -> alu_result=0.
- lw: instr=0x8C220008, rs_data=0x100 -> alu_result=0x108, alusrc=memread=memtoreg=regwrite=1, wrreg=2. A negative imm (0xFFF8) with rs_data=0x100 -> alu_result=0xF8.
- beq: instr=0x10220003, rs_data=rt_data=4 -> branch=1, zero=1, regwrite=0, aluop=01. Invalid opcode 0x3F -> all control 0.
- Reset: assert rst_n=0 mid-stream with outputs nonzero -> all outputs 0 without waiting for a clock edge. Release -> the next edge captures the current instruction. With OVF_DETECT_EN, 0x7FFFFFFF+1 -> ovf=1, alu_result=0x80000000.
